// File: rtl/reg_dump_tx.sv
// ---------------------------------------------------------------------------
// reg_dump_tx
//
// Serial readout engine for the 8-entry register file of the McCoy CPU.
// When it receives a start request, it takes over the register file read
// port and walks x0..x[LAST_REG] in order. Each value is sent on one pin as
// a framed serial word:
//
//   start(0), addr[2:0] MSB first, data[7:0] MSB first, [parity], stop(1)
//
// Every bit is held for CLKS_PER_BIT clocks. Before each frame the engine
// waits in WAIT until the sink raises tx_ready. Once a frame has started it
// always runs to the end.
//
// Build option:
//   REG_DUMP_PARITY_EN - when defined, an even-parity bit (XOR of addr and
//                        data) is placed before the stop bit. This gives a
//                        14-bit frame instead of 13 bits. The ports are the
//                        same in both builds.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (1..255)
//   LAST_REG      highest register index dumped (0..7)
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-low reset
//   start     dump request, sampled only in IDLE
//   tx_ready  sink flow control, sampled only in WAIT
//   rd_data   register file read data (combinational from rd_addr)
//   rd_addr   register file read address, valid while rd_busy is high
//   rd_busy   high for the whole dump; the CPU must not write registers
//   tx        serial output, idles high
//   done      one-cycle pulse when the dump completes
// ---------------------------------------------------------------------------
module reg_dump_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int LAST_REG     = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tx_ready,
    input  logic [7:0] rd_data,
    output logic [2:0] rd_addr,
    output logic       rd_busy,
    output logic       tx,
    output logic       done
);

`ifdef REG_DUMP_PARITY_EN
    localparam int FRAME_BITS = 14;
`else
    localparam int FRAME_BITS = 13;
`endif

    localparam logic [3:0] LAST_BIT  = 4'(FRAME_BITS - 1);
    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_ADDR = 3'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [7:0]              baud_cnt;
    logic [3:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   frame_sr;
    logic                    baud_wrap;
    logic                    bit_last;
    logic                    addr_last;

`ifdef REG_DUMP_PARITY_EN
    // Even parity: the parity bit makes the total number of ones
    // across addr, data and parity even.
    function automatic logic even_parity(input logic [10:0] bits);
        return ^bits;
    endfunction
`endif

    // Builds the complete frame, MSB first. The MSB is shifted out first.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [2:0] addr,
        input logic [7:0] data
    );
`ifdef REG_DUMP_PARITY_EN
        return {1'b0, addr, data, even_parity({addr, data}), 1'b1};
`else
        return {1'b0, addr, data, 1'b1};
`endif
    endfunction

    assign baud_wrap = (state == S_SHIFT) && (baud_cnt == BAUD_LAST);
    assign bit_last  = (bit_cnt == LAST_BIT);
    assign addr_last = (rd_addr == LAST_ADDR);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        rd_busy    = 1'b0;
        tx         = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                rd_busy    = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                rd_busy = 1'b1;
                if (tx_ready) begin
                    next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                rd_busy = 1'b1;
                tx      = frame_sr[FRAME_BITS-1];
                if (baud_wrap && bit_last) begin
                    next_state = addr_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Baud/bit counters and register index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            rd_addr  <= '0;
        end else begin
            case (state)
                S_SHIFT: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_last) begin
                            bit_cnt <= '0;
                            // The index only moves forward between frames. On
                            // the final frame it stays in place, and DONE
                            // clears it.
                            if (!addr_last) begin
                                rd_addr <= rd_addr + 3'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    rd_addr  <= '0;
                end
                default: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame shift register (data path, no reset needed: it is only
    // observed in SHIFT, and every SHIFT is preceded by a FETCH load)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == S_FETCH) begin
            frame_sr <= build_frame(rd_addr, rd_data);
        end else if (baud_wrap) begin
            frame_sr <= {frame_sr[FRAME_BITS-2:0], 1'b1};
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
module tb_reg_dump_tx;

    localparam int CPB = 4;
`ifdef REG_DUMP_PARITY_EN
    localparam int FB = 14;
`else
    localparam int FB = 13;
`endif
    localparam int PER_REG = 2 + FB * CPB;

    typedef struct {
        logic [2:0]  idx;
        logic [7:0]  data;
        logic [12:0] frame;   // hand-built frame without parity
        logic        par;     // hand-computed even-parity bit
    } vec_t;

    vec_t vec [8];
    logic [7:0] regs [8];

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       start0;
    logic       tx_ready;
    logic [7:0] rd_data;
    logic [7:0] rd_data0;
    logic [2:0] rd_addr;
    logic [2:0] rd_addr0;
    logic       rd_busy;
    logic       rd_busy0;
    logic       tx;
    logic       tx0;
    logic       done;
    logic       done0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dn    = 0;

    always #5 clk = ~clk;

    assign rd_data  = regs[rd_addr];
    assign rd_data0 = regs[rd_addr0];

    reg_dump_tx #(.CLKS_PER_BIT(CPB), .LAST_REG(7)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_ready(tx_ready),
        .rd_data(rd_data), .rd_addr(rd_addr), .rd_busy(rd_busy),
        .tx(tx), .done(done)
    );

    reg_dump_tx #(.CLKS_PER_BIT(CPB), .LAST_REG(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .tx_ready(tx_ready),
        .rd_data(rd_data0), .rd_addr(rd_addr0), .rd_busy(rd_busy0),
        .tx(tx0), .done(done0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (done === 1'b1) dn++;
    endtask

    function automatic logic [13:0] expected_frame(input int i);
`ifdef REG_DUMP_PARITY_EN
        return {vec[i].frame[12:1], vec[i].par, 1'b1};
`else
        return {1'b0, vec[i].frame};
`endif
    endfunction

    // Full dump on the LAST_REG=7 instance, checked cycle by cycle.
    task automatic run_dump(input int stall, input bit toggle_rdy, input bit inject_start);
        logic [13:0] got;
        logic        b0;
        int          unstable;
        int          stall_bad;
        dn = 0;
        tx_ready = (stall == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        chk("start_latency_busy", 32'(rd_busy), 32'd1);
        for (int f = 0; f < 8; f++) begin
            chk($sformatf("fetch_addr%0d", f), 32'(rd_addr), 32'(vec[f].idx));
            chk($sformatf("fetch_tx%0d", f), 32'(tx), 32'd1);
            tick();
            if (f == 0 && stall > 0) begin
                stall_bad = 0;
                for (int s = 0; s < stall; s++) begin
                    if (!(tx === 1'b1 && rd_busy === 1'b1)) stall_bad++;
                    tick();
                end
                chk("stall_idle_high", 32'(stall_bad), 32'd0);
            end
            tx_ready = 1'b1;
            chk($sformatf("wait_tx%0d", f), 32'(tx), 32'd1);
            got = '0;
            b0 = 1'b0;
            unstable = 0;
            for (int b = 0; b < FB; b++) begin
                for (int k = 0; k < CPB; k++) begin
                    tick();
                    if (k == 0) begin
                        b0 = tx;
                        got = {got[12:0], tx};
                    end else if (tx !== b0) begin
                        unstable++;
                    end
                    if (toggle_rdy)
                        tx_ready = (b == FB - 1 && k == CPB - 1) ? 1'b1 : ~tx_ready;
                    if (inject_start && f == 3 && b == 6)
                        start = (k == 0);
                end
            end
            chk($sformatf("frame%0d", f), 32'(got), 32'(expected_frame(f)));
            chk($sformatf("bit_hold%0d", f), 32'(unstable), 32'd0);
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy_low", 32'(rd_busy), 32'd0);
        chk("done_cycle", 32'(cyc), 32'(8 * PER_REG + stall));
        if (inject_start) start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_busy", 32'(rd_busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_addr", 32'(rd_addr), 32'd0);
        if (inject_start) begin
            tick();
            chk("no_restart", 32'(rd_busy), 32'd0);
        end
        chk("done_count", 32'(dn), 32'd1);
    endtask

    initial begin
        logic [13:0] got0;

        vec[0] = '{3'd0, 8'h00, 13'b0_000_00000000_1, 1'b0};
        vec[1] = '{3'd1, 8'hA5, 13'b0_001_10100101_1, 1'b1};
        vec[2] = '{3'd2, 8'h3C, 13'b0_010_00111100_1, 1'b1};
        vec[3] = '{3'd3, 8'h0F, 13'b0_011_00001111_1, 1'b0};
        vec[4] = '{3'd4, 8'h80, 13'b0_100_10000000_1, 1'b0};
        vec[5] = '{3'd5, 8'h01, 13'b0_101_00000001_1, 1'b1};
        vec[6] = '{3'd6, 8'hFF, 13'b0_110_11111111_1, 1'b0};
        vec[7] = '{3'd7, 8'h5A, 13'b0_111_01011010_1, 1'b1};
        for (int i = 0; i < 8; i++) regs[i] = vec[i].data;

        // Reset held with start asserted
        reset = 1'b0;
        start = 1'b1;
        start0 = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(rd_busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_addr", 32'(rd_addr), 32'd0);
            chk("rst_busy0", 32'(rd_busy0), 32'd0);
        end
        reset = 1'b1;
        start = 1'b0;
        start0 = 1'b0;
        tick();
        tick();
        chk("idle_tx", 32'(tx), 32'd1);

        // Full dump, then a back-to-back dump started from the IDLE cycle after DONE
        run_dump(0, 1'b0, 1'b0);
        run_dump(0, 1'b0, 1'b0);
        // Flow control stall, tx_ready toggling mid-frame, stray start pulses
        run_dump(20, 1'b1, 1'b1);

        // LAST_REG = 0: a single frame, then done
        tx_ready = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("l0_busy", 32'(rd_busy0), 32'd1);
        chk("l0_addr", 32'(rd_addr0), 32'd0);
        tick();
        chk("l0_wait_tx", 32'(tx0), 32'd1);
        got0 = '0;
        for (int b = 0; b < FB; b++) begin
            for (int k = 0; k < CPB; k++) begin
                tick();
                if (k == 0) got0 = {got0[12:0], tx0};
            end
        end
        chk("l0_frame", 32'(got0), 32'(expected_frame(0)));
        tick();
        chk("l0_done", 32'(done0), 32'd1);
        chk("l0_done_busy", 32'(rd_busy0), 32'd0);
        tick();
        chk("l0_done_once", 32'(done0), 32'd0);
        chk("l0_main_quiet", 32'(rd_busy), 32'd0);

        // Reset during bit 6 of frame 3
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3 * PER_REG + 26) tick();
        chk("mid_addr", 32'(rd_addr), 32'd3);
        chk("mid_bit6", 32'(tx), 32'd0);
        reset = 1'b0;
        tick();
        chk("mrst_tx", 32'(tx), 32'd1);
        chk("mrst_busy", 32'(rd_busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_addr", 32'(rd_addr), 32'd0);
        reset = 1'b1;
        dn = 0;
        repeat (10) tick();
        chk("mrst_no_done", 32'(dn), 32'd0);
        chk("mrst_stays_idle", 32'(rd_busy), 32'd0);

        // Recovery after the truncated frame
        run_dump(0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
